// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver on a shared oversample tick; samples each bit at its centre.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_HALF     = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL     = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] C_LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_busy;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  logic w_par_exp;

  assign w_par_exp  = (^r_shift) ^ PARITY_ODD;
  assign parity_err = r_parity_err;
`endif

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

  // Idle-high synchroniser so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (tick) begin
        case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_state <= S_START;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end

          S_START: begin
            if (r_cnt == C_HALF) begin
              r_cnt <= '0;
              if (!r_rx_s) begin
                r_state <= S_DATA;
                r_idx   <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_DATA: begin
            if (r_cnt == C_FULL) begin
              r_cnt   <= '0;
              r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_idx == C_LAST_BIT) begin
                r_idx <= '0;
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (r_cnt == C_FULL) begin
              r_cnt     <= '0;
              r_par_bit <= r_rx_s;
              r_state   <= S_STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`endif

          S_STOP: begin
            if (r_cnt == C_FULL) begin
              r_cnt <= '0;
              if (r_rx_s) begin
                // Leaving mid stop bit leaves half a bit to catch the next start edge.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (r_par_bit != w_par_exp) begin
                  r_parity_err <= 1'b1;
                end else begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end
`else
                r_data  <= r_shift;
                r_valid <= 1'b1;
`endif
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_WAIT_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_WAIT_IDLE: begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: vector table, hand sequences and random frames.
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx_oversampled;

  localparam int TICK_CLKS = 27;
  localparam int OS        = 16;
  localparam int BIT_CLKS  = TICK_CLKS * OS;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip_g = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] d;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] model_data;
  logic       prev_strobe = 1'b0;

  typedef struct {
    logic [7:0] b;
    logic       stop_ok;
    int         gap_bits;
    logic [1:0] exp_kind;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[4];

  uart_rx_oversampled #(
    .DATA_BITS (8),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (TICK_CLKS - 1) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Strobe monitor: records every pulse and enforces exclusivity / single-cycle width.
  always @(negedge clk) begin
    logic any;
    logic cnt2;
    any  = valid | frame_err;
    cnt2 = valid & frame_err;
`ifdef UART_RX_PARITY_EN
    cnt2 = cnt2 | (parity_err & any);
    any  = any | parity_err;
    if (parity_err) obs_q.push_back({K_PERR, data});
`endif
    if (valid) obs_q.push_back({K_VALID, data});
    if (frame_err) obs_q.push_back({K_FERR, data});
    if (any) chk("strobe_shape", {30'd0, cnt2, prev_strobe}, 32'd0);
    prev_strobe = any;
  end

  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    if (!stop_ok) exp_q.push_back({K_FERR, model_data});
    else if (!par_ok) exp_q.push_back({K_PERR, model_data});
    else begin
      exp_q.push_back({K_VALID, b});
      model_data = b;
    end
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      $display("%s: event %0d kind=%0d data=%02h (expected kind=%0d data=%02h)",
               tag, i, obs_q[i].kind, obs_q[i].d, exp_q[i].kind, exp_q[i].d);
      chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      chk({tag, "_data"}, obs_q[i].d, exp_q[i].d);
    end
    if (exp_q.size() == 0 && obs_q.size() == 0) $display("%s: no events", tag);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip_g);
`endif
    send_bit(stop);
  endtask

  initial begin
    logic bad;
    rst = 1'b1;
    rx  = 1'b1;
    model_data = 8'h00;

    tbl[0] = '{8'hA5, 1'b1, 1, K_VALID, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0, K_VALID, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1, K_VALID, 8'hFF, 1'b0};
    tbl[3] = '{8'h6B, 1'b0, 1, K_FERR,  8'hFF, 1'b1};

    // Reset state, then idle line for 1000 clocks.
    repeat (5) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("idle_outputs_quiet", bad, 1'b0);
    compare_events("idle");

    // Table-driven frames, including back-to-back 0x00 / 0xFF.
    for (int v = 0; v < 4; v++) begin
      send_frame(tbl[v].b, tbl[v].stop_ok);
      chk("tbl_busy_after_stop", busy, tbl[v].exp_busy);
      exp_q.push_back({tbl[v].exp_kind, tbl[v].exp_data});
      if (tbl[v].exp_kind == K_VALID) model_data = tbl[v].exp_data;
      compare_events($sformatf("tbl%0d_%02h", v, tbl[v].b));
      for (int g = 0; g < tbl[v].gap_bits; g++) send_bit(1'b1);
    end

    // Start-bit glitch of 4 ticks is rejected, then 0x3C is received.
    rx = 1'b0;
    repeat (3 * TICK_CLKS) @(negedge clk);
    chk("glitch_busy_high", busy, 1'b1);
    repeat (TICK_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("glitch_busy_low", busy, 1'b0);
    compare_events("glitch");
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b1);
    send_bit(1'b1);
    compare_events("after_glitch_3c");

    // Bad stop bit followed by a 20-bit break, then 0x55.
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (10 * BIT_CLKS) @(negedge clk);
    chk("break_busy_high", busy, 1'b1);
    repeat (10 * BIT_CLKS) @(negedge clk);
    chk("break_data_held", data, 8'h3C);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("break_busy_low", busy, 1'b0);
    compare_events("break");
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1, 1'b1);
    send_bit(1'b1);
    compare_events("after_break_55");

    // Reset after the 3rd data bit aborts silently, then 0x81.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", data, 8'h00);
    repeat (2 * BIT_CLKS) @(negedge clk);
    compare_events("abort");
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1, 1'b1);
    send_bit(1'b1);
    compare_events("after_abort_81");
`ifdef UART_RX_PARITY_EN
    par_flip_g = 1'b1;
    send_frame(8'h81, 1'b1);
    par_flip_g = 1'b0;
    model_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1);
    compare_events("parity_bad_81");
`endif

    // Random frames against the model.
    for (int r = 0; r < 4; r++) begin
      logic [7:0] b;
      logic       ok;
      int         gap;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      gap = ok ? int'($urandom_range(0, 1)) : 1;
      send_frame(b, ok);
      model_frame(b, ok, 1'b1);
      compare_events($sformatf("rand%0d_%02h", r, b));
      for (int g = 0; g < gap; g++) send_bit(1'b1);
    end
    send_bit(1'b1);
    chk("final_busy", busy, 1'b0);
    compare_events("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
